// File: rtl/midi_stream_arbiter_if.sv
// Bundles the two raw MIDI input streams and the parsed output stream of midi_stream_arbiter.
// slave = arbiter side, master = the side that feeds bytes in and consumes the parsed stream.
interface midi_stream_arbiter_if;
  logic       byteready_u;
  logic [7:0] byte_u;
  logic       byteready_c;
  logic [7:0] byte_c;
  logic       byteready;
  logic [7:0] cur_status;
  logic [7:0] midibyte_nr;
  logic [7:0] midi_in_data;
  logic       src_sel;
  logic       busy;
  logic       overflow_u;
  logic       overflow_c;

  modport slave (
    input  byteready_u, byte_u, byteready_c, byte_c,
    output byteready, cur_status, midibyte_nr, midi_in_data,
    output src_sel, busy, overflow_u, overflow_c
  );

  modport master (
    output byteready_u, byte_u, byteready_c, byte_c,
    input  byteready, cur_status, midibyte_nr, midi_in_data,
    input  src_sel, busy, overflow_u, overflow_c
  );
endinterface

// File: rtl/midi_stream_arbiter.sv
// Merges the UART and CPU MIDI byte streams into one parsed stream, switching source only
// between whole messages; each source has its own FIFO and running-status tracking.
module midi_stream_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int STALL = 1024
) (
  input  logic                  data_clk,
  input  logic                  reset_reg_N,
  midi_stream_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STALL) + 1;
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  // System real-time and undefined system bytes never enter the FIFOs.
  function automatic logic keep_byte(input logic [7:0] b);
    return !(b[7:4] == 4'hF && b != 8'hF0 && b != 8'hF7);
  endfunction

  // Data bytes per message; 0 means open-ended (SysEx, terminated by F7).
  function automatic logic [7:0] req_len(input logic [7:0] s);
    case (s[7:4])
      4'hC, 4'hD: return 8'd1;
      4'hF:       return 8'd0;
      default:    return 8'd2;
    endcase
  endfunction

  state_t          state_reg;
  logic            src_sel_reg;
  logic            last_grant_reg;
  logic            byteready_reg;
  logic [7:0]      cur_status_reg;
  logic [7:0]      midibyte_nr_reg;
  logic [7:0]      midi_in_data_reg;
  logic            msg_done_reg;
  logic [SW-1:0]   stall_reg;
  logic [7:0]      rs_reg  [2];
  logic [7:0]      cnt_reg [2];
  logic [1:0]      done_reg;

  logic [1:0]      in_vld;
  logic [7:0]      in_byte   [2];
  logic [1:0]      pop;
  logic [1:0]      empty;
  logic [1:0]      ovf;
  logic [7:0]      head_byte [2];

  assign in_vld[0]  = bus.byteready_u && keep_byte(bus.byte_u);
  assign in_vld[1]  = bus.byteready_c && keep_byte(bus.byte_c);
  assign in_byte[0] = bus.byte_u;
  assign in_byte[1] = bus.byte_c;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem_reg [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic          ovf_reg;
      logic          full;
      logic          wr_en;

      assign full         = (count_reg == FULL_CNT);
      // A full FIFO still takes a byte when the head leaves in the same cycle.
      assign wr_en        = in_vld[gi] && (!full || pop[gi]);
      assign empty[gi]    = (count_reg == '0);
      assign head_byte[gi] = mem_reg[rd_ptr_reg];
      assign ovf[gi]      = ovf_reg;
      assign pop[gi]      = (state_reg == FETCH) && (src_sel_reg == 1'(gi)) && !empty[gi];

      always_ff @(posedge data_clk) begin
        if (wr_en)
          mem_reg[wr_ptr_reg] <= in_byte[gi];
      end

      always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (pop[gi])
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop[gi]);
          if (in_vld[gi] && !wr_en)
            ovf_reg <= 1'b1;
        end
      end
    end
  endgenerate

  logic       grant_pick;
  logic       g_empty;
  logic [7:0] head;
  logic [7:0] rs_g;
  logic [7:0] cnt_g;
  logic [7:0] nr_next;
  logic [7:0] req;
  logic       data_complete;

  always_comb begin
    grant_pick = empty[0] ? 1'b1 : (empty[1] ? 1'b0 : ~last_grant_reg);
    g_empty    = empty[src_sel_reg];
    head       = head_byte[src_sel_reg];
    rs_g       = rs_reg[src_sel_reg];
    cnt_g      = cnt_reg[src_sel_reg];
    req        = req_len(rs_g);
    // Running status: after a completed message the next data byte restarts at index 1.
    if (done_reg[src_sel_reg])
      nr_next = 8'd1;
    else if (cnt_g == 8'hFF)
      nr_next = 8'hFF;
    else
      nr_next = cnt_g + 8'd1;
    data_complete = (req != 8'd0) && (nr_next == req);
  end

  always_ff @(posedge data_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_reg        <= IDLE;
      src_sel_reg      <= 1'b0;
      last_grant_reg   <= 1'b1;
      byteready_reg    <= 1'b0;
      cur_status_reg   <= '0;
      midibyte_nr_reg  <= '0;
      midi_in_data_reg <= '0;
      msg_done_reg     <= 1'b0;
      stall_reg        <= '0;
      rs_reg[0]        <= '0;
      rs_reg[1]        <= '0;
      cnt_reg[0]       <= '0;
      cnt_reg[1]       <= '0;
      done_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          byteready_reg <= 1'b0;
          if (!empty[0] || !empty[1]) begin
            src_sel_reg    <= grant_pick;
            last_grant_reg <= grant_pick;
            stall_reg      <= '0;
            state_reg      <= FETCH;
          end
        end

        FETCH: begin
          if (!g_empty) begin
            stall_reg <= '0;
            if (head == 8'hF7) begin
              if (rs_g == 8'hF0) begin
                cur_status_reg         <= 8'hF0;
                midibyte_nr_reg        <= nr_next;
                midi_in_data_reg       <= 8'hF7;
                rs_reg[src_sel_reg]    <= 8'h00;
                cnt_reg[src_sel_reg]   <= nr_next;
                done_reg[src_sel_reg]  <= 1'b1;
                msg_done_reg           <= 1'b1;
                byteready_reg          <= 1'b1;
                state_reg              <= EMIT;
              end else begin
                state_reg <= IDLE;
              end
            end else if (head[7]) begin
              // A status byte always opens a new message, even mid-message.
              rs_reg[src_sel_reg]   <= head;
              cnt_reg[src_sel_reg]  <= 8'd0;
              done_reg[src_sel_reg] <= 1'b0;
              cur_status_reg        <= head;
              midibyte_nr_reg       <= 8'd0;
              midi_in_data_reg      <= head;
              msg_done_reg          <= 1'b0;
              byteready_reg         <= 1'b1;
              state_reg             <= EMIT;
            end else if (rs_g == 8'h00) begin
              state_reg <= IDLE;
            end else begin
              cur_status_reg        <= rs_g;
              midibyte_nr_reg       <= nr_next;
              midi_in_data_reg      <= head;
              cnt_reg[src_sel_reg]  <= nr_next;
              done_reg[src_sel_reg] <= data_complete;
              msg_done_reg          <= data_complete;
              byteready_reg         <= 1'b1;
              state_reg             <= EMIT;
            end
          end else if (stall_reg == STALL_LAST) begin
            stall_reg <= '0;
            state_reg <= IDLE;
          end else begin
            stall_reg <= stall_reg + SW'(1);
          end
        end

        EMIT: begin
          byteready_reg <= 1'b0;
          state_reg     <= msg_done_reg ? IDLE : FETCH;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.byteready    = byteready_reg;
  assign bus.cur_status   = cur_status_reg;
  assign bus.midibyte_nr  = midibyte_nr_reg;
  assign bus.midi_in_data = midi_in_data_reg;
  assign bus.src_sel      = src_sel_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.overflow_u   = ovf[0];
  assign bus.overflow_c   = ovf[1];

endmodule
